// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 core: FSM states, opcode classes
// (high nibble) and error codes.
package chip8_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_HI = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_LATCH    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } err_t;

  localparam logic [3:0] OP_SYS     = 4'h0;
  localparam logic [3:0] OP_JP      = 4'h1;
  localparam logic [3:0] OP_CALL    = 4'h2;
  localparam logic [3:0] OP_SE_IMM  = 4'h3;
  localparam logic [3:0] OP_SNE_IMM = 4'h4;
  localparam logic [3:0] OP_SE_REG  = 4'h5;
  localparam logic [3:0] OP_LD_IMM  = 4'h6;
  localparam logic [3:0] OP_ADD_IMM = 4'h7;
  localparam logic [3:0] OP_ALU     = 4'h8;
  localparam logic [3:0] OP_SNE_REG = 4'h9;
  localparam logic [3:0] OP_LD_I    = 4'hA;
  localparam logic [3:0] OP_JP_V0   = 4'hB;

  localparam logic [15:0] INSTR_RET  = 16'h00EE;
  localparam logic [15:0] INSTR_EXIT = 16'h00FD;

endpackage

// File: rtl/chip8_if.sv
// Instruction-memory read port: address/strobe from the core, byte back one
// cycle later.
interface chip8_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;

  modport master (output mem_addr, output mem_rd, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

// File: rtl/chip8_alu.sv
// Combinational 8xyN register-register ALU; valid is low for undefined N.
module chip8_alu (
  input  logic [7:0] vx,
  input  logic [7:0] vy,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic       flag,
  output logic       writes_flag,
  output logic       valid
);

  logic [8:0] sum_s;

  // Result/flag selection by sub-opcode
  always_comb begin
    sum_s       = {1'b0, vx} + {1'b0, vy};
    result      = 8'h00;
    flag        = 1'b0;
    writes_flag = 1'b0;
    valid       = 1'b1;
    case (op)
      4'h0: result = vy;
      4'h1: result = vx | vy;
      4'h2: result = vx & vy;
      4'h3: result = vx ^ vy;
      4'h4: begin result = sum_s[7:0];        flag = sum_s[8];   writes_flag = 1'b1; end
      4'h5: begin result = vx - vy;           flag = (vx >= vy); writes_flag = 1'b1; end
      4'h6: begin result = {1'b0, vx[7:1]};   flag = vx[0];      writes_flag = 1'b1; end
      4'h7: begin result = vy - vx;           flag = (vy >= vx); writes_flag = 1'b1; end
      4'hE: begin result = {vx[6:0], 1'b0};   flag = vx[7];      writes_flag = 1'b1; end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/chip8_core.sv
// CHIP-8 subset core: 4-cycle fetch/latch/execute loop over a byte-wide
// instruction memory with a hardware return stack.
module chip8_core
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned START_PC    = 32'h200
) (
  input  logic              clk,
  input  logic              reset,
  chip8_if.master           mem,
  output logic [ADDR_W-1:0] debug_pc,
  output logic [ADDR_W-1:0] debug_i,
  output logic              halted,
  output logic [1:0]        error
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, i_r;
  logic [SP_W-1:0]   sp_r;
  logic [15:0]       instr_r;
  logic [7:0]        v_r [16];
  logic [ADDR_W-1:0] stack_r [STACK_DEPTH];
  err_t              error_r, err_code_s;

  logic [3:0]        op_hi_s, x_s, y_s, n_s;
  logic [7:0]        kk_s, vx_s, vy_s;
  logic [ADDR_W-1:0] nnn_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
  logic              is_ret_s, is_exit_s, ovf_s, unf_s, halt_req_s, skip_s;
  logic              rd_s, halted_s;
  logic [7:0]        alu_res_s;
  logic              alu_flag_s, alu_wf_s, alu_valid_s;

  assign op_hi_s  = instr_r[15:12];
  assign x_s      = instr_r[11:8];
  assign y_s      = instr_r[7:4];
  assign n_s      = instr_r[3:0];
  assign kk_s     = instr_r[7:0];
  assign nnn_s    = ADDR_W'(instr_r[11:0]);
  assign vx_s     = v_r[x_s];
  assign vy_s     = v_r[y_s];
  assign wr_idx_s = IDX_W'(sp_r);
  assign rd_idx_s = IDX_W'(sp_r - SP_W'(1'b1));

  chip8_alu u_alu (
    .vx          (vx_s),
    .vy          (vy_s),
    .op          (n_s),
    .result      (alu_res_s),
    .flag        (alu_flag_s),
    .writes_flag (alu_wf_s),
    .valid       (alu_valid_s)
  );

  // Control-flow decode of the latched instruction: faults, exit and skips
  always_comb begin
    is_ret_s   = (instr_r == INSTR_RET);
    is_exit_s  = (instr_r == INSTR_EXIT);
    ovf_s      = (op_hi_s == OP_CALL) && (sp_r == SP_W'(STACK_DEPTH));
    unf_s      = is_ret_s && (sp_r == {SP_W{1'b0}});
    halt_req_s = is_exit_s || ovf_s || unf_s;
    if (ovf_s) begin
      err_code_s = ERR_OVERFLOW;
    end else if (unf_s) begin
      err_code_s = ERR_UNDERFLOW;
    end else begin
      err_code_s = ERR_NONE;
    end
    case (op_hi_s)
      OP_SE_IMM:  skip_s = (vx_s == kk_s);
      OP_SNE_IMM: skip_s = (vx_s != kk_s);
      OP_SE_REG:  skip_s = (n_s == 4'h0) && (vx_s == vy_s);
      OP_SNE_REG: skip_s = (n_s == 4'h0) && (vx_s != vy_s);
      default:    skip_s = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH_HI;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    case (state_r)
      ST_FETCH_HI: state_nxt_s = ST_FETCH_LO;
      ST_FETCH_LO: state_nxt_s = ST_LATCH;
      ST_LATCH:    state_nxt_s = ST_EXEC;
      ST_EXEC:     state_nxt_s = halt_req_s ? ST_HALT : ST_FETCH_HI;
      ST_HALT:     state_nxt_s = ST_HALT;
      default:     state_nxt_s = ST_FETCH_HI;
    endcase
  end

  // FSM outputs; the read strobe is suppressed while reset is held
  always_comb begin
    rd_s     = 1'b0;
    halted_s = 1'b0;
    case (state_r)
      ST_FETCH_HI, ST_FETCH_LO: rd_s = !reset;
      ST_HALT:                  halted_s = 1'b1;
      default:                  rd_s = 1'b0;
    endcase
  end

  // Architectural state: PC, I, SP, V registers, instruction latch, error
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= ADDR_W'(START_PC);
      i_r     <= {ADDR_W{1'b0}};
      sp_r    <= {SP_W{1'b0}};
      instr_r <= 16'h0000;
      error_r <= ERR_NONE;
      for (int k = 0; k < 16; k++) v_r[k] <= 8'h00;
    end else begin
      case (state_r)
        ST_FETCH_HI: pc_r <= pc_r + ADDR_W'(1'b1);
        ST_FETCH_LO: begin
          instr_r[15:8] <= mem.mem_rdata;
          pc_r          <= pc_r + ADDR_W'(1'b1);
        end
        ST_LATCH: instr_r[7:0] <= mem.mem_rdata;
        ST_EXEC: begin
          if (halt_req_s) error_r <= err_code_s;
          case (op_hi_s)
            OP_SYS: if (is_ret_s && !unf_s) begin
              sp_r <= sp_r - SP_W'(1'b1);
              pc_r <= stack_r[rd_idx_s];
            end
            OP_JP: pc_r <= nnn_s;
            OP_CALL: if (!ovf_s) begin
              sp_r <= sp_r + SP_W'(1'b1);
              pc_r <= nnn_s;
            end
            OP_JP_V0:   pc_r <= nnn_s + ADDR_W'(v_r[0]);
            OP_LD_I:    i_r <= nnn_s;
            OP_LD_IMM:  v_r[x_s] <= kk_s;
            OP_ADD_IMM: v_r[x_s] <= vx_s + kk_s;
            // Flag write comes last so VF holds the flag when x is F
            OP_ALU: if (alu_valid_s) begin
              v_r[x_s] <= alu_res_s;
              if (alu_wf_s) v_r[4'hF] <= alu_flag_s ? 8'h01 : 8'h00;
            end
            OP_SE_IMM, OP_SNE_IMM, OP_SE_REG, OP_SNE_REG:
              if (skip_s) pc_r <= pc_r + ADDR_W'(2'd2);
            default: pc_r <= pc_r;
          endcase
        end
        default: pc_r <= pc_r;
      endcase
    end
  end

  // Return stack: written only by a successful CALL, never cleared
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_EXEC) && (op_hi_s == OP_CALL) && !ovf_s) begin
      stack_r[wr_idx_s] <= pc_r;
    end
  end

  assign mem.mem_addr = pc_r;
  assign mem.mem_rd   = rd_s;
  assign debug_pc     = pc_r;
  assign debug_i      = i_r;
  assign halted       = halted_s;
  assign error        = error_r;

endmodule

// File: tb/tb_chip8_core.sv
// Bench for chip8_core: ALU vector table, hand-written control-flow/fault
// sequences and random programs checked against an instruction-level model.
module tb_chip8_core;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  int   sel = 0;
  int   n_vec = 0, n_err = 0;

  logic [7:0] mem [4096];

  chip8_if #(.ADDR_W(12)) if0 ();
  chip8_if #(.ADDR_W(12)) if1 ();

  logic [11:0] pc0, pc1, i0, i1;
  logic        h0, h1;
  logic [1:0]  e0, e1;

  chip8_core #(.ADDR_W(12), .STACK_DEPTH(16), .START_PC(32'h200)) dut0 (
    .clk(clk), .reset(rst0), .mem(if0),
    .debug_pc(pc0), .debug_i(i0), .halted(h0), .error(e0));

  chip8_core #(.ADDR_W(12), .STACK_DEPTH(2), .START_PC(32'h200)) dut1 (
    .clk(clk), .reset(rst1), .mem(if1),
    .debug_pc(pc1), .debug_i(i1), .halted(h1), .error(e1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if0.mem_rdata <= mem[if0.mem_addr];
    if1.mem_rdata <= mem[if1.mem_addr];
  end

  logic [11:0] obs_pc, obs_i, obs_addr;
  logic        obs_rd, obs_halted;
  logic [1:0]  obs_err;
  assign obs_pc     = (sel == 1) ? pc1 : pc0;
  assign obs_i      = (sel == 1) ? i1 : i0;
  assign obs_addr   = (sel == 1) ? if1.mem_addr : if0.mem_addr;
  assign obs_rd     = (sel == 1) ? if1.mem_rd : if0.mem_rd;
  assign obs_halted = (sel == 1) ? h1 : h0;
  assign obs_err    = (sel == 1) ? e1 : e0;

  function automatic logic [127:0] dut_vregs();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = (sel == 1) ? dut1.v_r[k] : dut0.v_r[k];
    return r;
  endfunction

  function automatic int dut_sp();
    return (sel == 1) ? int'(dut1.sp_r) : int'(dut0.sp_r);
  endfunction

  // ---------------- reference model (one call = one instruction) ----------
  int m_pc, m_i, m_depth, m_err;
  int m_v [16];
  int m_stack [$];
  bit m_halted;

  function automatic void model_reset(input int depth);
    m_pc = 32'h200; m_i = 0; m_depth = depth; m_err = 0; m_halted = 1'b0;
    for (int k = 0; k < 16; k++) m_v[k] = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step();
    int op, x, y, n, kk, nnn, a, b;
    if (m_halted) return;
    op  = int'(mem[m_pc]) * 256 + int'(mem[(m_pc + 1) % 4096]);
    m_pc = (m_pc + 2) % 4096;
    x = (op >> 8) & 15; y = (op >> 4) & 15; n = op & 15; kk = op & 255; nnn = op & 4095;
    a = m_v[x]; b = m_v[y];
    case (op >> 12)
      0: if (op == 32'h00EE) begin
           if (m_stack.size() == 0) begin m_halted = 1'b1; m_err = 2; end
           else m_pc = m_stack.pop_back();
         end else if (op == 32'h00FD) begin
           m_halted = 1'b1; m_err = 0;
         end
      1: m_pc = nnn;
      2: if (m_stack.size() >= m_depth) begin m_halted = 1'b1; m_err = 1; end
         else begin m_stack.push_back(m_pc); m_pc = nnn; end
      3: if (a == kk) m_pc = (m_pc + 2) % 4096;
      4: if (a != kk) m_pc = (m_pc + 2) % 4096;
      5: if (n == 0 && a == b) m_pc = (m_pc + 2) % 4096;
      6: m_v[x] = kk;
      7: m_v[x] = (a + kk) % 256;
      8: case (n)
           0: m_v[x] = b;
           1: m_v[x] = a | b;
           2: m_v[x] = a & b;
           3: m_v[x] = a ^ b;
           4: begin m_v[x] = (a + b) % 256; m_v[15] = (a + b > 255) ? 1 : 0; end
           5: begin m_v[x] = (a - b + 256) % 256; m_v[15] = (a >= b) ? 1 : 0; end
           6: begin m_v[x] = a / 2; m_v[15] = a % 2; end
           7: begin m_v[x] = (b - a + 256) % 256; m_v[15] = (b >= a) ? 1 : 0; end
           14: begin m_v[x] = (a * 2) % 256; m_v[15] = a / 128; end
           default: ;
         endcase
      9: if (n == 0 && a != b) m_pc = (m_pc + 2) % 4096;
      10: m_i = nnn;
      11: m_pc = (nnn + m_v[0]) % 4096;
      default: ;
    endcase
  endfunction

  function automatic logic [127:0] model_vregs();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(m_v[k]);
    return r;
  endfunction

  // ---------------- helpers -----------------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
  endtask

  task automatic put(input int addr, input logic [15:0] w);
    mem[addr]     = w[15:8];
    mem[addr + 1] = w[7:0];
  endtask

  task automatic start(input int which);
    rst0 = 1'b1; rst1 = 1'b1;
    sel  = which;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset((which == 1) ? 2 : 16);
    if (which == 0) rst0 = 1'b0; else rst1 = 1'b0;
    #1;
  endtask

  // Four cycles of one instruction with per-cycle bus checks, then state checks
  task automatic run_one();
    bit run;
    run = !m_halted;
    for (int c = 0; c < 4; c++) begin
      check("mem_rd", obs_rd, (run && c < 2) ? 1'b1 : 1'b0);
      if (run && c < 2) check("mem_addr", obs_addr, (m_pc + c) % 4096);
      @(posedge clk);
      @(negedge clk);
    end
    model_step();
    check("pc", obs_pc, m_pc);
    check("i", obs_i, m_i);
    check("vregs", dut_vregs(), model_vregs());
    check("status", {obs_halted, obs_err}, {m_halted, 2'(m_err)});
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] x, y, n;
    logic [7:0] kk;
    x  = 4'($urandom_range(0, 15));
    y  = 4'($urandom_range(0, 15));
    n  = 4'($urandom_range(0, 15));
    kk = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    case ($urandom_range(0, 9))
      0, 9:    return {4'h6, x, kk};
      1:       return {4'h7, x, kk};
      2, 3:    return {4'h8, x, y, n};
      4:       return {4'h3, x, kk};
      5:       return {4'h4, x, kk};
      6:       return {4'h5, x, y, ($urandom_range(0, 1) == 1) ? 4'h0 : n};
      7:       return {4'h9, x, y, ($urandom_range(0, 1) == 1) ? 4'h0 : n};
      default: return {4'hA, x, kk};
    endcase
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [7:0] vx;
    logic [7:0] vy;
    logic [7:0] res;
    logic [7:0] vf;
  } alu_vec_t;

  alu_vec_t tbl [14];

  initial begin
    logic [127:0] vr;
    int pc_before;

    tbl[0]  = '{4'h0, 8'h12, 8'h34, 8'h34, 8'hAA};
    tbl[1]  = '{4'h1, 8'h0F, 8'hF0, 8'hFF, 8'hAA};
    tbl[2]  = '{4'h2, 8'h3C, 8'h0F, 8'h0C, 8'hAA};
    tbl[3]  = '{4'h3, 8'hFF, 8'h0F, 8'hF0, 8'hAA};
    tbl[4]  = '{4'h4, 8'hF0, 8'h20, 8'h10, 8'h01};
    tbl[5]  = '{4'h4, 8'h10, 8'h20, 8'h30, 8'h00};
    tbl[6]  = '{4'h5, 8'h10, 8'h20, 8'hF0, 8'h00};
    tbl[7]  = '{4'h5, 8'h20, 8'h20, 8'h00, 8'h01};
    tbl[8]  = '{4'h6, 8'h05, 8'h00, 8'h02, 8'h01};
    tbl[9]  = '{4'h7, 8'h10, 8'h30, 8'h20, 8'h01};
    tbl[10] = '{4'h7, 8'h30, 8'h10, 8'hE0, 8'h00};
    tbl[11] = '{4'hE, 8'h81, 8'h00, 8'h02, 8'h01};
    tbl[12] = '{4'hE, 8'h40, 8'h00, 8'h80, 8'h00};
    tbl[13] = '{4'h8, 8'h55, 8'h66, 8'h55, 8'hAA};

    // Load/add program, then reset out of a populated state
    clear_mem();
    put(32'h200, 16'h6A05); put(32'h202, 16'h7AFF); put(32'h204, 16'hA123);
    start(0);
    run_one(); run_one();
    vr = dut_vregs();
    check("prog_va", vr[87:80], 8'h04);
    check("prog_vf", vr[127:120], 8'h00);
    check("prog_pc", obs_pc, 12'h204);
    run_one();
    check("prog_i", obs_i, 12'h123);
    rst0 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_pc", obs_pc, 12'h200);
    check("rst_i", obs_i, 12'h000);
    check("rst_halted", obs_halted, 1'b0);
    check("rst_error", obs_err, 2'd0);
    check("rst_mem_rd", obs_rd, 1'b0);
    vr = dut_vregs();
    check("rst_vregs", vr, 128'h0);

    // ALU table
    for (int t = 0; t < 14; t++) begin
      clear_mem();
      put(32'h200, 16'h6FAA);
      put(32'h202, {8'h61, tbl[t].vx});
      put(32'h204, {8'h62, tbl[t].vy});
      put(32'h206, {8'h81, 4'h2, tbl[t].op});
      start(0);
      repeat (4) run_one();
      vr = dut_vregs();
      check($sformatf("alu%0d_v1", t), vr[15:8], tbl[t].res);
      check($sformatf("alu%0d_vf", t), vr[127:120], tbl[t].vf);
    end

    // Flag wins over result when the destination is VF
    clear_mem();
    put(32'h200, 16'h6FF0); put(32'h202, 16'h6120); put(32'h204, 16'h8F14);
    start(0);
    repeat (3) run_one();
    vr = dut_vregs();
    check("vf_dest_flag", vr[127:120], 8'h01);

    // Skip taken / not taken
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      put(32'h200, (t == 0) ? 16'h6305 : 16'h6306); put(32'h202, 16'h3305);
      start(0);
      run_one();
      pc_before = int'(obs_pc);
      run_one();
      check($sformatf("skip%0d_adv", t), int'(obs_pc) - pc_before, (t == 0) ? 4 : 2);
    end

    // CALL then RET
    clear_mem();
    put(32'h200, 16'h2300); put(32'h300, 16'h00EE);
    start(0);
    run_one();
    check("call_pc", obs_pc, 12'h300);
    check("call_sp", dut_sp(), 1);
    run_one();
    check("ret_pc", obs_pc, 12'h202);
    check("ret_sp", dut_sp(), 0);

    // Stack overflow on the depth-2 core, then HALT holds with no reads
    clear_mem();
    put(32'h200, 16'h2300); put(32'h300, 16'h2400); put(32'h400, 16'h2500);
    start(1);
    repeat (3) run_one();
    check("ovf_halted", obs_halted, 1'b1);
    check("ovf_error", obs_err, 2'd1);
    check("ovf_pc", obs_pc, 12'h402);
    repeat (2) run_one();

    // Underflow from reset, and EXIT
    clear_mem();
    put(32'h200, 16'h00EE);
    start(0);
    run_one();
    check("unf_halted", obs_halted, 1'b1);
    check("unf_error", obs_err, 2'd2);
    clear_mem();
    put(32'h200, 16'h00FD);
    start(0);
    run_one();
    check("exit_halted", obs_halted, 1'b1);
    check("exit_error", obs_err, 2'd0);
    run_one();

    // Bnnn wraps modulo 2^12
    clear_mem();
    put(32'h200, 16'h6002); put(32'h202, 16'hBFFF);
    start(0);
    repeat (2) run_one();
    check("bnnn_wrap_pc", obs_pc, 12'h001);

    // Reset during FETCH_LO discards the in-flight jump
    clear_mem();
    put(32'h200, 16'h1400);
    start(0);
    @(posedge clk); @(negedge clk);
    rst0 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midfetch_rst_pc", obs_pc, 12'h200);
    rst0 = 1'b0;
    #1;
    model_reset(16);
    run_one();
    check("midfetch_refetch_pc", obs_pc, 12'h400);

    // Random programs against the model
    for (int p = 0; p < 3; p++) begin
      clear_mem();
      for (int w = 0; w < 160; w++) put(32'h200 + 2 * w, rand_instr());
      start(0);
      repeat (60) run_one();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/chip8_core.md
CHIP8_CORE -- requirements
Module: chip8_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning program-counter, I and memory address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, meaning return-stack entries (>=1).
REQ-003 SHALL have parameter START_PC, default 'h200, meaning PC value after reset.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_addr  output  ADDR_W  instruction read address.
REQ-007 SHALL have port mem_rd  output  1  read strobe, high in cycles that issue a read.
REQ-008 SHALL have port mem_rdata  input  8  byte at the mem_addr presented one cycle earlier (1-cycle latency).
REQ-009 SHALL have port debug_pc  output  ADDR_W  current PC.
REQ-010 SHALL have port debug_i  output  ADDR_W  current I register.
REQ-011 SHALL have port halted  output  1  core stopped (EXIT or error).
REQ-012 SHALL have port error  output  2  0 none, 1 stack overflow, 2 stack underflow.

Function
REQ-013 SHALL implement states FETCH_HI, FETCH_LO, LATCH, EXEC, HALT. FETCH_HI drives mem_addr=pc, mem_rd=1, pc+=1. FETCH_LO captures mem_rdata into instr[15:8], drives mem_addr=pc, mem_rd=1, pc+=1. LATCH captures instr[7:0]. EXEC executes, then goes to FETCH_HI. Total: 4 cycles per instruction.
REQ-014 SHALL wrap all PC and I arithmetic modulo 2^ADDR_W; opcode address fields are truncated/zero-extended to ADDR_W.
REQ-015 SHALL execute: 00EE RET (sp-=1, pc=stack[sp-1]); 00FD EXIT (to HALT, error=0); 1nnn pc=nnn; 2nnn stack[sp]=pc, sp+=1, pc=nnn; Bnnn pc=nnn+V0; Annn I=nnn.
REQ-016 SHALL skip (pc+=2) on: 3xkk Vx==kk; 4xkk Vx!=kk; 5xy0 Vx==Vy; 9xy0 Vx!=Vy.
REQ-017 SHALL execute: 6xkk Vx=kk; 7xkk Vx=Vx+kk mod 256, VF unchanged.
REQ-018 SHALL execute 8xyN: 0 Vx=Vy; 1 OR; 2 AND; 3 XOR; 4 Vx=Vx+Vy, VF=carry; 5 Vx=Vx-Vy, VF=(Vx>=Vy); 6 Vx=Vx>>1, VF=old Vx[0]; 7 Vx=Vy-Vx, VF=(Vy>=Vx); E Vx=Vx<<1, VF=old Vx[7]. All arithmetic 8-bit, mod 256.
REQ-019 SHALL, when x==F on a flag-setting 8xyN, leave VF holding the flag, not the result.
REQ-020 SHALL treat every other opcode (including 5xyN/9xyN with N!=0 and undefined 8xyN) as NOP with pc unchanged beyond fetch.
REQ-021 SHALL, on CALL with sp==STACK_DEPTH, not write the stack, set error=1, enter HALT.
REQ-022 SHALL, on RET with sp==0, set error=2, enter HALT.
REQ-023 SHALL in HALT hold all state, drive mem_rd=0, halted=1, until reset.
REQ-024 SHALL hold mem_rd=0 in LATCH and EXEC; mem_addr value is don't-care when mem_rd=0.

Reset
REQ-025 SHALL on reset set pc=START_PC, I=0, sp=0, all V=0, instr=0, state=FETCH_HI, halted=0, error=0, mem_rd=0; reset in any state (including mid-fetch or HALT) takes effect at the next edge, discarding the in-flight instruction.
REQ-026 SHALL issue the first read in the first cycle after reset deasserts.

Structure
REQ-027 SHALL place the state enum, opcode-class constants (high nibble values) and error codes in shared package chip8_pkg.
REQ-028 SHALL implement 8xyN in combinational sub-module chip8_alu (inputs vx, vy, op[3:0]; outputs result[7:0], flag, writes_flag, valid).
REQ-029 SHALL hold stack contents in a STACK_DEPTH x ADDR_W register array; the stack SHALL NOT be cleared on reset.

Verification
REQ-030 SHALL verify: reset, program 6A05 7AFF at 'h200 -> after 8 cycles VA='h04, VF=0, debug_pc='h204.
REQ-031 SHALL verify: V1='hF0, V2='h20, 8124 -> V1='h10, VF=1; then 8125 with V1='h10, V2='h20 -> V1='hF0, VF=0.
REQ-032 SHALL verify: 3305 with V3=5 -> debug_pc advances by 4; with V3=6 -> advances by 2.
REQ-033 SHALL verify: 2300 at 'h200 then 00EE at 'h300 -> pc='h300 after CALL, 'h202 after RET, sp back to 0.
REQ-034 SHALL verify: STACK_DEPTH=2, three nested CALLs -> halted=1, error=1, mem_rd stays 0; 00EE first from reset -> error=2.
REQ-035 SHALL verify: ADDR_W=12, B FFF with V0='h02 -> pc='h001 (wrap); reset asserted in FETCH_LO -> pc=START_PC, instruction not executed.
